// File: rtl/id_ex_ctrl_pipe_pkg.sv
// id_ex_ctrl_pipe_pkg
//   Shared pipeline definitions for the ID/EX control bundle: bundle width,
//   bit offsets of each control field, the bubble (NOP) value, the packed
//   bundle typedef used by the decoder and the EX stage, and the squash
//   window length clamp helper.
package id_ex_ctrl_pipe_pkg;

  localparam int CTRL_W = 12;

  // Bit offsets inside the packed bundle (MSB first):
  // {RegWrite, ALUOp[2:0], ALUSrc, RegDst, Branch, Jump, MemRead, MemWrite, MemtoReg, BranchType}
  localparam int REG_WRITE_BIT   = 11;
  localparam int ALU_OP_MSB      = 10;
  localparam int ALU_OP_LSB      = 8;
  localparam int ALU_SRC_BIT     = 7;
  localparam int REG_DST_BIT     = 6;
  localparam int BRANCH_BIT      = 5;
  localparam int JUMP_BIT        = 4;
  localparam int MEM_READ_BIT    = 3;
  localparam int MEM_WRITE_BIT   = 2;
  localparam int MEM_TO_REG_BIT  = 1;
  localparam int BRANCH_TYPE_BIT = 0;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  localparam int MAX_SQUASH = 3;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch_type;
  } ctrl_bundle_t;

  // A requested length of 0 still kills the slot being written (1 cycle);
  // anything longer than the window limit is clamped to the limit.
  function automatic int unsigned eff_squash_len(input int unsigned len,
                                                 input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/id_ex_ctrl_pipe_squash_ctr.sv
// id_ex_ctrl_pipe_squash_ctr
//   Squash window counter. A flush writes one bubble itself and leaves
//   (effective length - 1) further bubble cycles pending; a new flush can
//   only extend the pending window, never shorten it.
// Ports
//   clk         in   1      clock, rising edge
//   srst        in   1      synchronous reset, active-high
//   flush       in   1      start / extend squash window
//   squash_len  in   CNT_W  requested window length, sampled with flush
//   busy        out  1      registered: squash cycles remain after this edge
//   bubble_now  out  1      combinational: this edge must write a bubble
module id_ex_ctrl_pipe_squash_ctr
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int MAX_SQUASH_LEN = 3,
  parameter int CNT_W          = $clog2(MAX_SQUASH_LEN + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic [CNT_W-1:0] squash_len,
  output logic             busy,
  output logic             bubble_now
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] target;

  // Remaining cycles after the flush edge itself.
  assign target = CNT_W'(eff_squash_len(32'(squash_len), 32'(MAX_SQUASH_LEN)) - 1);

  always_comb begin
    cnt_next   = cnt_reg;
    bubble_now = 1'b0;
    if (flush) begin
      bubble_now = 1'b1;
      cnt_next   = (cnt_reg > target) ? cnt_reg : target;
    end else if (cnt_reg != '0) begin
      bubble_now = 1'b1;
      cnt_next   = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe
//   ID/EX control-bundle pipeline register with hold (stall), bubble
//   insertion (flush) and a multi-cycle squash window.
//   Edge priority: reset > flush > pending squash > stall > load.
// Ports
//   clk_i         in   1       clock, rising edge
//   rst_i         in   1       synchronous reset, active-high
//   ctrl_i        in   CTRL_W  control bundle from decoder
//   valid_i       in   1       ctrl_i holds a real instruction
//   stall_i       in   1       hold current contents
//   flush_i       in   1       start squash window
//   squash_len_i  in   CNT_W   window length, sampled with flush_i
//   ctrl_o        out  CTRL_W  registered bundle to EX
//   valid_o       out  1       registered valid to EX
//   squash_busy_o out  1       squash cycles remain after current edge
//   bubble_cnt_o  out  16      saturating count of bubbles written
module id_ex_ctrl_pipe
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int                CTRL_W     = id_ex_ctrl_pipe_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] NOP_CTRL   = '0,
  parameter int                MAX_SQUASH = id_ex_ctrl_pipe_pkg::MAX_SQUASH,
  localparam int               CNT_W      = $clog2(MAX_SQUASH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [CNT_W-1:0]  squash_len_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic              squash_busy_o,
  output logic [15:0]       bubble_cnt_o
);

  logic [CTRL_W-1:0] ctrl_reg;
  logic              valid_reg;
  logic [15:0]       bubble_cnt_reg;
  logic              squash_bubble;
  logic              write_bubble;

  id_ex_ctrl_pipe_squash_ctr #(
    .MAX_SQUASH_LEN (MAX_SQUASH),
    .CNT_W          (CNT_W)
  ) u_squash_ctr (
    .clk        (clk_i),
    .srst       (rst_i),
    .flush      (flush_i),
    .squash_len (squash_len_i),
    .busy       (squash_busy_o),
    .bubble_now (squash_bubble)
  );

  // An unstalled load of an invalid slot is also a bubble, so it is counted
  // and its ctrl_i never reaches EX.
  assign write_bubble = squash_bubble || (!stall_i && !valid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_reg  <= NOP_CTRL;
      valid_reg <= 1'b0;
    end else if (squash_bubble) begin
      ctrl_reg  <= NOP_CTRL;
      valid_reg <= 1'b0;
    end else if (!stall_i) begin
      valid_reg <= valid_i;
      ctrl_reg  <= valid_i ? ctrl_i : NOP_CTRL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_reg <= '0;
    end else if (write_bubble && (bubble_cnt_reg != 16'hFFFF)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
    end
  end

  assign ctrl_o       = ctrl_reg;
  assign valid_o      = valid_reg;
  assign bubble_cnt_o = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb_id_ex_ctrl_pipe
//   Scoreboard bench for id_ex_ctrl_pipe: every driven edge pushes the
//   expected outputs from a behavioural model; the entry is popped and
//   compared after the edge. Scenario tasks add fixed-value checks.
module tb_id_ex_ctrl_pipe;
  import id_ex_ctrl_pipe_pkg::*;

  localparam int CNT_W = $clog2(MAX_SQUASH + 1);

  logic              clk;
  logic              rst;
  logic [CTRL_W-1:0] ctrl_in;
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic [CNT_W-1:0]  squash_len;
  logic [CTRL_W-1:0] ctrl_out;
  logic              valid_out;
  logic              busy;
  logic [15:0]       bub_cnt;

  id_ex_ctrl_pipe dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ctrl_i        (ctrl_in),
    .valid_i       (valid_in),
    .stall_i       (stall),
    .flush_i       (flush),
    .squash_len_i  (squash_len),
    .ctrl_o        (ctrl_out),
    .valid_o       (valid_out),
    .squash_busy_o (busy),
    .bubble_cnt_o  (bub_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic              busy;
    logic [15:0]       bub;
  } exp_t;

  exp_t sb[$];

  // Behavioural model state
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_valid;
  int                m_cnt;
  int                m_bub;

  int n_cmp;
  int n_bad;
  bit quiet;

  task automatic step(input logic r, input logic f, input logic [CNT_W-1:0] l,
                      input logic s, input logic v, input logic [CTRL_W-1:0] c);
    exp_t e;
    int   eff;
    bit   bubble;
    rst = r; flush = f; squash_len = l; stall = s; valid_in = v; ctrl_in = c;
    bubble = 1'b0;
    if (r) begin
      m_ctrl = '0; m_valid = 1'b0; m_cnt = 0; m_bub = 0;
    end else begin
      if (f) begin
        eff = (l == 0) ? 1 : ((int'(l) > MAX_SQUASH) ? MAX_SQUASH : int'(l));
        if (eff - 1 > m_cnt) m_cnt = eff - 1;
        bubble = 1'b1;
      end else if (m_cnt != 0) begin
        m_cnt  = m_cnt - 1;
        bubble = 1'b1;
      end else if (!s) begin
        m_valid = v;
        m_ctrl  = v ? c : '0;
        bubble  = !v;
      end
      if (bubble) begin
        m_ctrl = '0; m_valid = 1'b0;
        if (m_bub != 16'hFFFF) m_bub = m_bub + 1;
      end
    end
    e.ctrl = m_ctrl; e.valid = m_valid; e.busy = (m_cnt != 0); e.bub = 16'(m_bub);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({ctrl_out, valid_out, busy, bub_cnt} !== {e.ctrl, e.valid, e.busy, e.bub}) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t: got ctrl=%h valid=%b busy=%b bub=%h, want ctrl=%h valid=%b busy=%b bub=%h",
               $time, ctrl_out, valid_out, busy, bub_cnt, e.ctrl, e.valid, e.busy, e.bub);
    end
    n_cmp++;
    if (!valid_out && (ctrl_out !== NOP_CTRL)) begin
      n_bad++;
      $display("FAIL nop_when_invalid t=%0t: got ctrl=%h with valid=0, want %h", $time, ctrl_out, NOP_CTRL);
    end
    if (!quiet)
      $display("txn t=%0t rst=%b flush=%b len=%0d stall=%b v=%b c=%h -> ctrl=%h valid=%b busy=%b bub=%0d",
               $time, r, f, l, s, v, c, ctrl_out, valid_out, busy, bub_cnt);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 1, 12'hFFF);
    step(1, 0, 0, 0, 1, 12'hFFF);
    n_cmp++;
    if (ctrl_out !== 12'h000 || valid_out !== 1'b0 || bub_cnt !== 16'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got ctrl=%h valid=%b bub=%0d busy=%b, want 000 0 0 0", ctrl_out, valid_out, bub_cnt, busy);
    end
  endtask

  task automatic test_stall();
    step(0, 0, 0, 0, 1, 12'hA53);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 12'h111);
      n_cmp++;
      if (ctrl_out !== 12'hA53 || valid_out !== 1'b1 || bub_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got ctrl=%h valid=%b bub=%0d, want a53 1 0", i, ctrl_out, valid_out, bub_cnt);
      end
    end
  endtask

  task automatic test_squash();
    logic [2:0] busy_seq;
    step(0, 1, 2'd3, 0, 1, 12'h101);
    busy_seq[2] = busy;
    step(0, 0, 0, 0, 1, 12'h102);
    busy_seq[1] = busy;
    step(0, 0, 0, 0, 1, 12'h103);
    busy_seq[0] = busy;
    n_cmp++;
    if (busy_seq !== 3'b110) begin
      n_bad++;
      $display("FAIL squash_busy_seq: got %b, want 110", busy_seq);
    end
    step(0, 0, 0, 0, 1, 12'h104);
    n_cmp++;
    if (ctrl_out !== 12'h104 || valid_out !== 1'b1 || bub_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL squash_fourth_load: got ctrl=%h valid=%b bub=%0d, want 104 1 3", ctrl_out, valid_out, bub_cnt);
    end
  endtask

  // Drives valid loads until one reaches EX; returns how many edges wrote bubbles.
  task automatic run_until_valid(input logic [CTRL_W-1:0] base, output int bubbles);
    bubbles = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, base + CTRL_W'(i));
      if (valid_out) break;
      bubbles++;
    end
  endtask

  task automatic test_overlap_and_len();
    int         nb;
    logic [2:0] big;
    // Second flush (len 1) leaves max(2, 0)=2 pending, so the window is
    // extended by the second flush edge itself: 4 bubble edges in total.
    step(0, 1, 2'd3, 0, 1, 12'h201);
    step(0, 1, 2'd1, 0, 1, 12'h202);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_not_shortened: got busy=%b, want 1", busy);
    end
    run_until_valid(12'h210, nb);
    n_cmp++;
    if (nb + 2 !== 4) begin
      n_bad++;
      $display("FAIL overlap_bubbles: got %0d, want 4", nb + 2);
    end
    step(0, 1, 2'd0, 0, 1, 12'h220);
    n_cmp++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_one_bubble: got busy=%b valid=%b, want 0 0", busy, valid_out);
    end
    run_until_valid(12'h230, nb);
    n_cmp++;
    if (nb !== 0) begin
      n_bad++;
      $display("FAIL len0_followup: got %0d extra bubbles, want 0", nb);
    end
    // A request of 7 cannot exceed the 2-bit port; it arrives as 3 (the limit).
    big = 3'd7;
    step(0, 1, big[CNT_W-1:0], 0, 1, 12'h240);
    run_until_valid(12'h250, nb);
    n_cmp++;
    if (nb + 1 !== 3 || bub_cnt !== 16'd11) begin
      n_bad++;
      $display("FAIL len_clamp: got bubbles=%0d bub=%0d, want 3 11", nb + 1, bub_cnt);
    end
  endtask

  task automatic test_stall_flush();
    step(0, 1, 2'd2, 1, 1, 12'h301);
    n_cmp++;
    if (valid_out !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_flush_same_edge: got valid=%b busy=%b, want 0 1", valid_out, busy);
    end
    step(0, 0, 0, 1, 1, 12'h302);
    n_cmp++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || bub_cnt !== 16'd13) begin
      n_bad++;
      $display("FAIL stall_ignored_in_window: got valid=%b busy=%b bub=%0d, want 0 0 13", valid_out, busy, bub_cnt);
    end
    step(0, 0, 0, 1, 1, 12'h303);
    n_cmp++;
    if (valid_out !== 1'b0 || ctrl_out !== 12'h000 || bub_cnt !== 16'd13) begin
      n_bad++;
      $display("FAIL stall_hold_bubble: got valid=%b ctrl=%h bub=%0d, want 0 000 13", valid_out, ctrl_out, bub_cnt);
    end
    step(0, 0, 0, 0, 1, 12'h304);
    n_cmp++;
    if (ctrl_out !== 12'h304 || valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release: got ctrl=%h valid=%b, want 304 1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_reset_window();
    step(0, 1, 2'd3, 0, 1, 12'h400);
    step(1, 0, 0, 0, 1, 12'h4FF);
    n_cmp++;
    if (busy !== 1'b0 || bub_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid_window: got busy=%b bub=%0d, want 0 0", busy, bub_cnt);
    end
    step(0, 0, 0, 0, 1, 12'h401);
    n_cmp++;
    if (ctrl_out !== 12'h401 || valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reset_load: got ctrl=%h valid=%b, want 401 1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_saturate();
    quiet = 1'b1;
    for (int i = 0; i < 65534; i++) step(0, 0, 0, 0, 0, 12'hFFF);
    quiet = 1'b0;
    n_cmp++;
    if (bub_cnt !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL preload: got bub=%h, want fffe", bub_cnt);
    end
    step(0, 1, 2'd3, 0, 1, 12'h501);
    step(0, 0, 0, 0, 1, 12'h502);
    step(0, 0, 0, 0, 1, 12'h503);
    n_cmp++;
    if (bub_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL saturate: got bub=%h, want ffff", bub_cnt);
    end
    step(0, 0, 0, 0, 0, 12'h504);
    n_cmp++;
    if (bub_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL saturate_no_wrap: got bub=%h, want ffff", bub_cnt);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; quiet = 1'b0;
    m_ctrl = '0; m_valid = 1'b0; m_cnt = 0; m_bub = 0;
    rst = 1'b1; flush = 1'b0; squash_len = '0; stall = 1'b0; valid_in = 1'b0; ctrl_in = '0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_squash();
    test_overlap_and_len();
    test_stall_flush();
    test_reset_window();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
